// File: rtl/fsm_event_seg_disp_if.sv
// Event inputs from the control FSM and the multiplexed seven-segment drive.
interface fsm_event_seg_disp_if;
  logic       y0_in;
  logic       y1_in;
  logic       clr;
  logic [3:0] an;
  logic [7:0] sseg;

  modport master (output y0_in, output y1_in, output clr, input an, input sseg);
  modport slave  (input y0_in, input y1_in, input clr, output an, output sseg);
endinterface

// File: rtl/fsm_event_seg_disp.sv
// Counts y0 pulses and S2 entries (y1 falling edges) in two BCD counters
// and shows both on a time-multiplexed 4-digit common-anode display.
module fsm_event_seg_disp #(
  parameter int N = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_event_seg_disp_if.slave  bus
);

  logic         y0_d, y1_d;
  logic         ev0, ev1;
  logic [3:0]   d0, d1, d2, d3;
  logic [N-1:0] refresh;
  logic [1:0]   sel;
  logic [3:0]   digit;
  logic         dp;
  logic [3:0]   an_c;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens, ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; out-of-range codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign ev0 = bus.y0_in & ~y0_d;
  assign ev1 = ~bus.y1_in & y1_d;

  // Delay flops reset high so an input already high at release is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y0_d    <= 1'b1;
      y1_d    <= 1'b1;
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
      refresh <= '0;
    end else begin
      y0_d    <= bus.y0_in;
      y1_d    <= bus.y1_in;
      refresh <= refresh + {{(N-1){1'b0}}, 1'b1};
      if (bus.clr) begin
        d0 <= 4'd0;
        d1 <= 4'd0;
        d2 <= 4'd0;
        d3 <= 4'd0;
      end else begin
        if (ev0) {d1, d0} <= bcd_inc({d1, d0});
        if (ev1) {d3, d2} <= bcd_inc({d3, d2});
      end
    end
  end

  assign sel = refresh[N-1 -: 2];

  always_comb begin
    an_c  = 4'b1110;
    digit = d0;
    dp    = 1'b1;
    case (sel)
      2'd0: begin an_c = 4'b1110; digit = d0; end
      2'd1: begin an_c = 4'b1101; digit = d1; end
      2'd2: begin an_c = 4'b1011; digit = d2; dp = 1'b0; end
      2'd3: begin an_c = 4'b0111; digit = d3; end
      default: ;
    endcase
  end

  assign bus.an   = an_c;
  assign bus.sseg = {dp, seg_decode(digit)};

endmodule

// File: tb/tb_fsm_event_seg_disp.sv
// Directed bench for fsm_event_seg_disp with N=4 (4 cycles per digit).
module tb_fsm_event_seg_disp;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fsm_event_seg_disp_if bus_if ();

  fsm_event_seg_disp #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seg_exp(input int d, input bit dp_lit);
    logic [7:0] t;
    case (d)
      0: t = 8'hC0;
      1: t = 8'hF9;
      2: t = 8'hA4;
      3: t = 8'hB0;
      4: t = 8'h99;
      5: t = 8'h92;
      6: t = 8'h82;
      7: t = 8'hF8;
      8: t = 8'h80;
      9: t = 8'h90;
      default: t = 8'hBF;
    endcase
    if (dp_lit) t[7] = 1'b0;
    return t;
  endfunction

  // Wait (bounded) until digit idx is enabled, then check its segments.
  task automatic read_digit(input string tag, input int idx, input int val);
    logic [3:0] pat;
    pat = ~(4'b0001 << idx);
    for (int i = 0; i < 20 && bus_if.an !== pat; i++) tick();
    chk({tag, "_an"}, 32'(bus_if.an), 32'(pat));
    chk({tag, "_seg"}, 32'(bus_if.sseg), 32'(seg_exp(val, idx == 2)));
  endtask

  task automatic check_cnt0(input string tag, input int v);
    read_digit({tag, "_d0"}, 0, v % 10);
    read_digit({tag, "_d1"}, 1, v / 10);
  endtask

  task automatic check_cnt1(input string tag, input int v);
    read_digit({tag, "_d2"}, 2, v % 10);
    read_digit({tag, "_d3"}, 3, v / 10);
  endtask

  task automatic pulse_y0(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.y0_in = 1'b1;
      tick();
      bus_if.y0_in = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_y1(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.y1_in = 1'b0;
      tick();
      bus_if.y1_in = 1'b1;
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset        = 1'b1;
    bus_if.y0_in = 1'b1;
    bus_if.y1_in = 1'b1;
    bus_if.clr   = 1'b0;

    // 1: reset release with both inputs high
    repeat (3) tick();
    reset = 1'b0;
    chk("t1_c0_an", 32'(bus_if.an), 32'h0000000E);
    chk("t1_c0_seg", 32'(bus_if.sseg), 32'h000000C0);
    repeat (8) tick();
    chk("t1_c8_an", 32'(bus_if.an), 32'h0000000B);
    chk("t1_c8_seg", 32'(bus_if.sseg), 32'h00000040);
    check_cnt0("t1_cnt0", 0);
    check_cnt1("t1_cnt1", 0);

    // 2: five 1-cycle pulses, then one 3-cycle pulse
    bus_if.y0_in = 1'b0;
    tick();
    pulse_y0(5);
    check_cnt0("t2_five", 5);
    bus_if.y0_in = 1'b1;
    repeat (3) tick();
    bus_if.y0_in = 1'b0;
    tick();
    check_cnt0("t2_six", 6);

    // 3: bring to 98, then 100 pulses with carry/wrap checkpoints
    pulse_y0(92);
    check_cnt0("t3_98", 98);
    pulse_y0(1);
    check_cnt0("t3_99", 99);
    pulse_y0(1);
    check_cnt0("t3_wrap00", 0);
    pulse_y0(9);
    check_cnt0("t3_09", 9);
    pulse_y0(1);
    check_cnt0("t3_carry10", 10);
    pulse_y0(88);
    check_cnt0("t3_back98", 98);
    check_cnt1("t3_cnt1", 0);

    // 4: three S2 entries
    pulse_y1(3);
    check_cnt1("t4_cnt1", 3);
    check_cnt0("t4_cnt0", 98);

    // 5: clr, count to 42, then clr against a rising edge
    bus_if.clr = 1'b1;
    tick();
    bus_if.clr = 1'b0;
    check_cnt0("t5_clr0", 0);
    check_cnt1("t5_clr1", 0);
    pulse_y0(42);
    check_cnt0("t5_42", 42);
    bus_if.y0_in = 1'b1;
    bus_if.clr   = 1'b1;
    tick();
    bus_if.clr = 1'b0;
    bus_if.y0_in = 1'b0;
    check_cnt0("t5_clr_wins", 0);
    pulse_y0(1);
    check_cnt0("t5_after", 1);

    // 6: reset mid-sequence with y0 held high
    pulse_y0(3);
    pulse_y1(2);
    check_cnt0("t6_pre", 4);
    bus_if.y0_in = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_an", 32'(bus_if.an), 32'h0000000E);
    chk("t6_seg", 32'(bus_if.sseg), 32'h000000C0);
    repeat (5) tick();
    check_cnt0("t6_cnt0", 0);
    check_cnt1("t6_cnt1", 0);
    bus_if.y0_in = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
